byte_queue: RTL and testbench

Downstream stage of the serial-to-byte deserializer: captures each completed byte offered on the deserializer's `data_ready`/`data_out` pair, acknowledges it with a single-cycle pulse on the deserializer's `ack_in`, and buffers it in a small circular FIFO. A consumer drains bytes through a show-ahead valid/ready port. One clock domain; the FIFO decouples consumer stalls from the serial line so the deserializer is released as soon as buffer space exists.

---
 rtl/byte_queue_pkg.sv | 6 +
 rtl/byte_ack_fsm.sv | 32 +++
 rtl/byte_queue.sv | 61 ++++++
 tb/tb_byte_queue.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_queue_pkg.sv
// byte_queue_pkg: shared capture-state type and default sizes for the byte queue
package byte_queue_pkg;
    typedef enum logic [1:0] {IDLE, ACK, WAIT_DROP} cap_state_t;
    localparam int BQ_DEPTH = 8;
    localparam int BQ_WIDTH = 8;
endpackage

// File: rtl/byte_ack_fsm.sv
// byte_ack_fsm: capture handshake toward the deserializer
//   clk_100mhz, reset (async, active-low)
//   byte_ready : deserializer data_ready level
//   full       : queue has no free entry
//   push       : write the offered byte this edge
//   ack_out    : one-cycle acknowledge pulse to the deserializer
module byte_ack_fsm
    import byte_queue_pkg::*;
(
    input  logic clk_100mhz,
    input  logic reset,
    input  logic byte_ready,
    input  logic full,
    output logic push,
    output logic ack_out
);
    cap_state_t state, state_nxt;

    always_ff @(posedge clk_100mhz or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nxt;

    // WAIT_DROP holds off capture until data_ready falls, so a level that
    // lingers after the ack is never taken as a second byte.
    always_comb begin
        push      = (state == IDLE) && byte_ready && !full;
        ack_out   = (state == ACK);
        state_nxt = push ? ACK :
                    (state == ACK) ? WAIT_DROP :
                    (state == WAIT_DROP && !byte_ready) ? IDLE : state;
    end
endmodule

// File: rtl/byte_queue.sv
// byte_queue: captures deserializer bytes with an ack handshake into a circular FIFO
//   clk_100mhz, reset (async, active-low)
//   byte_in/byte_ready/ack_out : deserializer side
//   data_out/valid_out/ready_in : show-ahead consumer side
//   count_out : occupancy 0..DEPTH, full_out : count_out == DEPTH
module byte_queue
    import byte_queue_pkg::*;
#(
    parameter int DEPTH = BQ_DEPTH,
    parameter int WIDTH = BQ_WIDTH
) (
    input  logic                     clk_100mhz,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         byte_in,
    input  logic                     byte_ready,
    output logic                     ack_out,
    output logic [WIDTH-1:0]         data_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     full_out
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;

    byte_ack_fsm u_fsm (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .byte_ready (byte_ready),
        .full       (full_out),
        .push       (push),
        .ack_out    (ack_out)
    );

    assign valid_out = count != '0;
    assign full_out  = count == CNT_W'(DEPTH);
    assign count_out = count;
    assign pop       = valid_out && ready_in;
    assign data_out  = valid_out ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_100mhz)
        if (push) mem[wr_ptr] <= byte_in;

    // Occupancy is its own counter; push is already blocked when full,
    // so simultaneous push/pop nets to zero change.
    always_ff @(posedge clk_100mhz or negedge reset)
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
endmodule

// File: tb/tb_byte_queue.sv
// tb_byte_queue: randomized and directed checks of byte_queue against a queue model
module tb_byte_queue;
    import byte_queue_pkg::*;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic             clk_100mhz = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] byte_in = '0;
    logic             byte_ready = 1'b0;
    logic             ready_in = 1'b0;
    logic             ack_out, valid_out, full_out;
    logic [WIDTH-1:0] data_out;
    logic [3:0]       count_out;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] mq[$];
    int phase = 0;

    always #5 clk_100mhz = ~clk_100mhz;

    byte_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_ready (byte_ready),
        .ack_out    (ack_out),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .count_out  (count_out),
        .full_out   (full_out)
    );

    function automatic logic [WIDTH-1:0] exp_data();
        return mq.size() != 0 ? mq[0] : 8'h00;
    endfunction

    // One clock edge; the model applies the handshake and FIFO rules at the edge.
    // phase: 0 = ready to capture, 1 = acking, 2 = waiting for data_ready to drop.
    task automatic step();
        bit cap, pp;
        @(posedge clk_100mhz);
        cap = (phase == 0) && byte_ready && (mq.size() < DEPTH);
        pp  = (mq.size() > 0) && ready_in;
        if (pp) void'(mq.pop_front());
        if (cap) mq.push_back(byte_in);
        phase = cap ? 1 : (phase == 1) ? 2 : (phase == 2 && !byte_ready) ? 0 : phase;
        @(negedge clk_100mhz);
    endtask

    task automatic offer(input logic [WIDTH-1:0] b, output int acks);
        acks = 0;
        byte_in = b;
        byte_ready = 1'b1;
        for (int i = 0; i < 40 && acks == 0; i++) begin
            step();
            if (ack_out) acks++;
        end
        byte_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ack_out) acks++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk_100mhz);
        @(negedge clk_100mhz);
        checks++; if (ack_out !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_out); end
        checks++; if (count_out !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_out); end
        checks++; if (full_out !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full_out); end
        mq.delete();
        phase = 0;
        reset = 1'b1;
    endtask

    task automatic test_single_byte();
        int acks = 0;
        byte_in = 8'h55;
        byte_ready = 1'b1;
        step();
        checks++; if (ack_out !== 1'b1) begin errors++; $display("FAIL first_edge_capture: ack got %b expected 1", ack_out); end
        if (ack_out) acks++;
        checks++; if (acks !== 1) begin errors++; $display("FAIL single_ack_count: got %0d expected 1", acks); end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", valid_out); end
        checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL single_data: got %h expected 55", data_out); end
        checks++; if (count_out !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count_out); end
    endtask

    task automatic test_handshake_hold();
        int acks = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ack_out) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL hold_extra_ack: got %0d expected 0", acks); end
        checks++; if (count_out !== 4'd1) begin errors++; $display("FAIL hold_count: got %0d expected 1", count_out); end
        byte_ready = 1'b0;
        step();
        step();
        checks++; if (count_out !== 4'd1) begin errors++; $display("FAIL hold_drop_count: got %0d expected 1", count_out); end
    endtask

    task automatic test_fill();
        int acks;
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL fill_pre_empty: got %b expected 0", valid_out); end
        for (int b = 1; b <= 8; b++) begin
            offer(8'(b), acks);
            checks++; if (acks !== 1) begin errors++; $display("FAIL fill_ack_%0d: got %0d acks expected 1", b, acks); end
        end
        checks++; if (full_out !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full_out); end
        checks++; if (count_out !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d expected 8", count_out); end
        acks = 0;
        byte_in = 8'hAA;
        byte_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ack_out) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL full_no_ack: got %0d acks expected 0", acks); end
        checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL full_head: got %h expected 01", data_out); end
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        checks++; if (ack_out !== 1'b0) begin errors++; $display("FAIL pop_no_same_edge_push: ack got %b expected 0", ack_out); end
        checks++; if (count_out !== 4'd7) begin errors++; $display("FAIL pop_count: got %0d expected 7", count_out); end
        for (int i = 0; i < 10 && acks == 0; i++) begin
            step();
            if (ack_out) acks++;
        end
        checks++; if (acks !== 1) begin errors++; $display("FAIL ninth_ack: got %0d acks expected 1", acks); end
        checks++; if (count_out !== 4'd8) begin errors++; $display("FAIL ninth_count: got %0d expected 8", count_out); end
        byte_ready = 1'b0;
        step();
        step();
    endtask

    task automatic test_drain_order();
        logic [WIDTH-1:0] seq [8];
        for (int i = 0; i < 7; i++) seq[i] = 8'(i + 2);
        seq[7] = 8'hAA;
        ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (data_out !== seq[i]) begin errors++; $display("FAIL drain_%0d: got %h expected %h", i, data_out, seq[i]); end
            step();
        end
        ready_in = 1'b0;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", valid_out); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL drain_data: got %h expected 00", data_out); end
        step();
        checks++; if (count_out !== 4'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", count_out); end
    endtask

    task automatic test_back_to_back();
        int acks;
        for (int i = 0; i < 3; i++) offer(8'($urandom), acks);
        checks++; if (count_out !== 4'd3) begin errors++; $display("FAIL bb_pre_count: got %0d expected 3", count_out); end
        for (int i = 0; i < 6; i++) begin
            byte_in = 8'($urandom);
            byte_ready = 1'b1;
            ready_in = 1'b1;
            step();
            ready_in = 1'b0;
            byte_ready = 1'b0;
            checks++; if (count_out !== 4'd3) begin errors++; $display("FAIL bb_count_%0d: got %0d expected 3", i, count_out); end
            checks++; if (ack_out !== 1'b1) begin errors++; $display("FAIL bb_ack_%0d: got %b expected 1", i, ack_out); end
            checks++; if (data_out !== exp_data()) begin errors++; $display("FAIL bb_head_%0d: got %h expected %h", i, data_out, exp_data()); end
            step();
            step();
        end
        ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (data_out !== exp_data()) begin errors++; $display("FAIL bb_drain_%0d: got %h expected %h", i, data_out, exp_data()); end
            step();
        end
        ready_in = 1'b0;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL bb_empty: got %b expected 0", valid_out); end
    endtask

    task automatic test_random();
        int gap = 0;
        for (int c = 0; c < 3000; c++) begin
            if (byte_ready && ack_out) begin
                byte_ready = 1'b0;
                gap = 2 + int'($urandom_range(0, 3));
            end else if (!byte_ready) begin
                if (gap > 0) gap--;
                else if ($urandom_range(0, 2) == 0) begin
                    byte_in = 8'($urandom);
                    byte_ready = 1'b1;
                end
            end
            ready_in = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step();
            checks++; if (data_out !== exp_data()) begin errors++; $display("FAIL rnd_data@%0d: got %h expected %h", c, data_out, exp_data()); end
            checks++; if (valid_out !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, valid_out, mq.size() != 0); end
            checks++; if (count_out !== 4'(mq.size())) begin errors++; $display("FAIL rnd_count@%0d: got %0d expected %0d", c, count_out, mq.size()); end
            checks++; if (full_out !== (mq.size() == DEPTH)) begin errors++; $display("FAIL rnd_full@%0d: got %b expected %b", c, full_out, mq.size() == DEPTH); end
            checks++; if (ack_out !== (phase == 1)) begin errors++; $display("FAIL rnd_ack@%0d: got %b expected %b", c, ack_out, phase == 1); end
        end
        byte_ready = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i < 12; i++) step();
        ready_in = 1'b0;
        checks++; if (count_out !== 4'd0) begin errors++; $display("FAIL rnd_final_count: got %0d expected 0", count_out); end
    endtask

    task automatic test_reset_mid();
        int acks;
        for (int i = 0; i < 4; i++) offer(8'($urandom), acks);
        byte_in = 8'($urandom);
        byte_ready = 1'b1;
        step();
        checks++; if (ack_out !== 1'b1) begin errors++; $display("FAIL mid_in_ack: got %b expected 1", ack_out); end
        checks++; if (count_out !== 4'd5) begin errors++; $display("FAIL mid_count_pre: got %0d expected 5", count_out); end
        #2 reset = 1'b0;
        #1;
        checks++; if (ack_out !== 1'b0) begin errors++; $display("FAIL mid_ack: got %b expected 0", ack_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", valid_out); end
        checks++; if (count_out !== 4'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", count_out); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_data: got %h expected 00", data_out); end
        checks++; if (dut.u_fsm.state !== IDLE) begin errors++; $display("FAIL mid_state: got %0d expected %0d", dut.u_fsm.state, IDLE); end
        byte_ready = 1'b0;
        mq.delete();
        phase = 0;
        @(negedge clk_100mhz);
        @(negedge clk_100mhz);
        reset = 1'b1;
        step();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_release_valid: got %b expected 0", valid_out); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_handshake_hold();
        test_fill();
        test_drain_order();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
